// File: rtl/issue_execute_fifo.sv
// issue_execute_fifo: buffers issued ops between the issue stage and one execute unit.
// Latency: push to data_out_valid is 1 cycle; 0 cycles when built with ISSUE_EXECUTE_FIFO_BYPASS_EN.
// Backpressure: full (registered state only) drops pushes; pop on an empty FIFO is ignored.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   data_in, push         op from issue and its enqueue request
//   full, count           no free entry / current occupancy
//   data_out,
//   data_out_valid, pop   show-ahead head entry, presence flag, consume request
//   commit_feedback_pack  commit feedback; enable & flush empties the FIFO
//
// Optional build macro: ISSUE_EXECUTE_FIFO_BYPASS_EN (an empty FIFO forwards data_in
// to data_out in the same cycle).

package issue_execute_pkg;

  typedef struct packed {
    logic        enable;
    logic [5:0]  rob_id;
    logic [3:0]  opcode;
    logic [4:0]  dst_reg;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } issue_execute_pack_t;

  typedef struct packed {
    logic       enable;
    logic       flush;
    logic [5:0] rob_id;
  } commit_feedback_pack_t;

endpackage

module issue_execute_fifo
  import issue_execute_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  issue_execute_pack_t     data_in,
  input  logic                    push,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output issue_execute_pack_t     data_out,
  output logic                    data_out_valid,
  input  logic                    pop,
  input  commit_feedback_pack_t   commit_feedback_pack
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty never alias.
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  issue_execute_pack_t storage_q [DEPTH];
  issue_execute_pack_t storage_d [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             empty;
  logic             flush_req;
  logic             push_acc;
  logic             pop_acc;
  logic             bypass_consume;
  logic             wr_en;
  logic             rd_adv;

  // Only enable/flush of the feedback pack matter here.
  logic fb_unused;
  assign fb_unused = ^commit_feedback_pack.rob_id;

  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign wr_idx = wr_ptr_q[IDX_W-1:0];

  // Status and handshake qualification.
  always_comb begin
    flush_req = commit_feedback_pack.enable & commit_feedback_pack.flush;
    empty     = (rd_ptr_q == wr_ptr_q);
    full      = (rd_idx == wr_idx) && (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    count     = wr_ptr_q - rd_ptr_q;
    push_acc  = push & ~full & ~flush_req;
  end

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  logic bypass_hit;

  // An empty FIFO presents the incoming op directly; if the execute unit
  // takes it in the same cycle, it never touches storage.
  always_comb begin
    bypass_hit     = empty & push & ~flush_req;
    bypass_consume = bypass_hit & pop;
    data_out_valid = ~empty | bypass_hit;
    data_out       = bypass_hit ? data_in : storage_q[rd_idx];
  end
`else
  // Outputs depend on registered state only.
  always_comb begin
    bypass_consume = 1'b0;
    data_out_valid = ~empty;
    data_out       = storage_q[rd_idx];
  end
`endif

  always_comb begin
    pop_acc = pop & data_out_valid & ~flush_req;
    // A bypass-consumed op moves neither pointer.
    wr_en   = push_acc & ~bypass_consume;
    rd_adv  = pop_acc  & ~bypass_consume;
  end

  // Next-state: flush wins over any push/pop in the same cycle and leaves
  // storage contents untouched.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    storage_d = storage_q;
    if (flush_req) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (wr_en) begin
        storage_d[wr_idx] = data_in;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      storage_q <= storage_d;
    end
  end

endmodule

// File: tb/tb_issue_execute_fifo.sv
// tb_issue_execute_fifo: directed scenarios plus random traffic against a queue model.
// Latency: inputs driven 1 time unit after posedge; outputs sampled 1 unit later.
// Backpressure: model drops pushes at DEPTH entries and pops when nothing is present.

module tb_issue_execute_fifo;
  import issue_execute_pkg::*;

  localparam int DEPTH = 4;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  issue_execute_pack_t   data_in;
  logic                  push;
  logic                  full;
  logic [2:0]            count;
  issue_execute_pack_t   data_out;
  logic                  data_out_valid;
  logic                  pop;
  commit_feedback_pack_t cf_pack;

  int n_checks = 0;
  int n_fail   = 0;

  issue_execute_pack_t model_q[$];

  issue_execute_fifo #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_in              (data_in),
    .push                 (push),
    .full                 (full),
    .count                (count),
    .data_out             (data_out),
    .data_out_valid       (data_out_valid),
    .pop                  (pop),
    .commit_feedback_pack (cf_pack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.enable  = 1'b1;
    p.rob_id  = rob[5:0];
    p.opcode  = 4'($urandom);
    p.dst_reg = 5'($urandom);
    p.src_a   = $urandom;
    p.src_b   = $urandom;
    return p;
  endfunction

  // Model view of the outputs for the inputs currently applied.
  function automatic void model_expect(output logic v, output issue_execute_pack_t d,
                                       output int c, output logic f);
    logic fl;
    fl = cf_pack.enable & cf_pack.flush;
    c  = model_q.size();
    f  = (c == DEPTH);
    if (c > 0) begin
      v = 1'b1;
      d = model_q[0];
    end else if (BYP && push && !fl) begin
      v = 1'b1;
      d = data_in;
    end else begin
      v = 1'b0;
      d = '0;
    end
  endfunction

  // Model update for the clock edge about to happen.
  function automatic void model_apply();
    int  sz;
    bit  pop_ok;
    bit  push_ok;
    sz = model_q.size();
    if (cf_pack.enable && cf_pack.flush) begin
      model_q.delete();
    end else if (!(BYP && sz == 0 && push && pop)) begin
      pop_ok  = pop && (sz > 0);
      push_ok = push && (sz < DEPTH);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(data_in);
    end
  endfunction

  task automatic drive(input logic p, input issue_execute_pack_t d, input logic po, input logic fl);
    push          = p;
    data_in       = d;
    pop           = po;
    cf_pack       = '0;
    cf_pack.enable = fl;
    cf_pack.flush  = fl;
    cf_pack.rob_id = 6'($urandom);
    #1;
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = '0; cf_pack = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_out_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
    rst = 1'b1;
    model_q.delete();
    tick();
    n_checks++; if (data_out_valid !== 1'b0 || data_out.enable !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset valid=%b enable=%b want 0/0", data_out_valid, data_out.enable);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    drive(1'b1, mk(5), 1'b0, 1'b0);
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_drop_count got %0d want 4", count); end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (data_out_valid !== 1'b1 || data_out.rob_id !== 6'(i)) begin
        n_fail++; $display("FAIL fill_pop_order valid=%b rob=%0d want 1/%0d", data_out_valid, data_out.rob_id, i);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained_valid got %b want 0", data_out_valid); end
  endtask

  task automatic test_steady();
    drive(1'b1, mk(0), 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, mk(i), 1'b1, 1'b0);
      n_checks++; if (count !== 3'd1 || full !== 1'b0 || data_out.rob_id !== 6'(i - 1)) begin
        n_fail++; $display("FAIL steady cnt=%0d full=%b rob=%0d want 1/0/%0d", count, full, data_out.rob_id, i - 1);
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (data_out.rob_id !== 6'd9) begin n_fail++; $display("FAIL steady_last rob=%0d want 9", data_out.rob_id); end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(4), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd0 || data_out_valid !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL flush_state cnt=%0d valid=%b full=%b want 0/0/0", count, data_out_valid, full);
    end
    drive(1'b1, mk(7), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (data_out_valid !== 1'b1 || data_out.rob_id !== 6'd7 || count !== 3'd1) begin
      n_fail++; $display("FAIL flush_next_push valid=%b rob=%0d cnt=%0d want 1/7/1", data_out_valid, data_out.rob_id, count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_full_pop();
    for (int i = 11; i <= 14; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(15), 1'b1, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullpop_full got %b want 1", full); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd3 || data_out.rob_id !== 6'd12) begin
      n_fail++; $display("FAIL fullpop_drop cnt=%0d rob=%0d want 3/12", count, data_out.rob_id);
    end
    drive(1'b1, mk(16), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4 || full !== 1'b1) begin
      n_fail++; $display("FAIL fullpop_refill cnt=%0d full=%b want 4/1", count, full);
    end
    for (int i = 0; i < 4; i++) begin
      int exp_rob;
      exp_rob = (i == 3) ? 16 : 12 + i;
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (data_out.rob_id !== 6'(exp_rob)) begin
        n_fail++; $display("FAIL fullpop_drain rob=%0d want %0d", data_out.rob_id, exp_rob);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 20; i <= 21; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (data_out_valid !== 1'b0 || count !== 3'd0 || data_out !== '0) begin
      n_fail++; $display("FAIL async_reset valid=%b cnt=%0d data=%h want 0/0/0", data_out_valid, count, data_out);
    end
    model_q.delete();
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    logic                exp_v;
    issue_execute_pack_t exp_d;
    int                  exp_c;
    logic                exp_f;
    drive(1'b1, mk(9), 1'b1, 1'b0);
    model_expect(exp_v, exp_d, exp_c, exp_f);
    n_checks++; if (data_out_valid !== BYP || count !== 3'd0) begin
      n_fail++; $display("FAIL bypass_same_cycle valid=%b cnt=%0d want %b/0", data_out_valid, count, BYP);
    end
    n_checks++; if (exp_v && data_out !== exp_d) begin
      n_fail++; $display("FAIL bypass_data got rob=%0d want rob=%0d", data_out.rob_id, exp_d.rob_id);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== (BYP ? 3'd0 : 3'd1)) begin
      n_fail++; $display("FAIL bypass_after cnt=%0d want %0d", count, BYP ? 0 : 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic                exp_v;
    issue_execute_pack_t exp_d;
    int                  exp_c;
    logic                exp_f;
    int                  rob;
    rob = 30;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 60, mk(rob), $urandom_range(0, 99) < 50,
            $urandom_range(0, 15) == 0);
      rob++;
      model_expect(exp_v, exp_d, exp_c, exp_f);
      n_checks++; if (data_out_valid !== exp_v || count !== 3'(exp_c) || full !== exp_f) begin
        n_fail++; $display("FAIL random_status cyc=%0d valid=%b cnt=%0d full=%b want %b/%0d/%b",
                           n, data_out_valid, count, full, exp_v, exp_c, exp_f);
      end
      n_checks++; if (exp_v && data_out !== exp_d) begin
        n_fail++; $display("FAIL random_data cyc=%0d rob=%0d want rob=%0d", n, data_out.rob_id, exp_d.rob_id);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_flush();
    test_full_pop();
    test_async_reset();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
